// File: rtl/mem_access_stage.sv
// Memory stage: ALU results pass through, and loads/stores run on a req/ack port while upstream is stalled.
// Optional MEM_TIMEOUT_EN: an ack watchdog aborts the access after TIMEOUT busy cycles and sets sticky mem_err.
module mem_access_stage #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MWE_i,
  input  logic              Mux_i,
  input  logic              RWE_i,
  input  logic [15:0]       Res_i,
  input  logic [15:0]       DATA_B_i,
  input  logic [7:0]        C_Reg_i,
  output logic              stall,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [15:0]       dm_wdata,
  input  logic [15:0]       dm_rdata,
  input  logic              dm_ack,
  output logic              wb_RWE,
  output logic [15:0]       wb_data,
  output logic [7:0]        wb_C_Reg,
  output logic              mem_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic        mwe;
    logic        mux;
    logic        rwe;
    logic [15:0] res;
    logic [15:0] data;
    logic [7:0]  creg;
  } mem_req_t;

  state_t   state;
  mem_req_t lat;
  logic     memop, busy, is_load, to_hit;

  assign memop   = MWE_i | Mux_i;
  assign busy    = (state == BUSY);
  // A request with both bits set behaves as a store, so only a pure read picks up memory data.
  assign is_load = lat.mux & ~lat.mwe;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt;
  logic             err_q;
  assign to_hit  = busy & ~dm_ack & (cnt == CNT_W'(TIMEOUT - 1));
  assign mem_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign to_hit  = 1'b0;
  assign mem_err = 1'b0;
`endif

  // The memory port is driven straight from the latches, so it holds steady for the whole access.
  assign dm_req   = busy;
  assign dm_we    = busy & lat.mwe;
  assign dm_addr  = lat.res[ADDR_W-1:0];
  assign dm_wdata = lat.data;
  assign stall    = busy ? ~(dm_ack | to_hit) : memop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      lat      <= '0;
      wb_RWE   <= 1'b0;
      wb_data  <= '0;
      wb_C_Reg <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt      <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (memop) begin
            lat    <= '{mwe: MWE_i, mux: Mux_i, rwe: RWE_i,
                        res: Res_i, data: DATA_B_i, creg: C_Reg_i};
            state  <= BUSY;
            wb_RWE <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt    <= '0;
`endif
          end else begin
            wb_RWE   <= RWE_i;
            wb_data  <= Res_i;
            wb_C_Reg <= C_Reg_i;
          end
        end
        BUSY: begin
          if (dm_ack) begin
            state    <= IDLE;
            wb_RWE   <= lat.rwe;
            wb_C_Reg <= lat.creg;
            wb_data  <= is_load ? dm_rdata : lat.res;
          end else if (to_hit) begin
            state  <= IDLE;
            wb_RWE <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            err_q  <= 1'b1;
`endif
          end else begin
            wb_RWE <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt    <= cnt + 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: a vector table, directed corner sequences and a randomized run
// checked against a program-order write-back queue and memory-array model.
module tb_mem_access_stage;
`ifdef MEM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 15;
`endif
  localparam int N_RND = 300;

  logic clk = 1'b0, rst_n;
  logic MWE_i, Mux_i, RWE_i, stall, dm_req, dm_we, dm_ack, wb_RWE, mem_err;
  logic [15:0] Res_i, DATA_B_i, dm_addr, dm_wdata, dm_rdata, wb_data;
  logic [7:0]  C_Reg_i, wb_C_Reg;

  mem_access_stage #(.ADDR_W(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .MWE_i(MWE_i), .Mux_i(Mux_i), .RWE_i(RWE_i),
    .Res_i(Res_i), .DATA_B_i(DATA_B_i), .C_Reg_i(C_Reg_i), .stall(stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .wb_RWE(wb_RWE), .wb_data(wb_data),
    .wb_C_Reg(wb_C_Reg), .mem_err(mem_err));

  always #5 clk = ~clk;

  int ncmp = 0, nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic mwe, input logic mux, input logic rwe,
                     input logic [15:0] res, input logic [15:0] db, input logic [7:0] cr);
    MWE_i = mwe; Mux_i = mux; RWE_i = rwe; Res_i = res; DATA_B_i = db; C_Reg_i = cr;
  endtask

  task automatic idle_in();
    drv(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 8'h0);
  endtask

  // Inputs change at the falling edge; everything is sampled 1 ns later.
  task automatic cyc();
    @(negedge clk);
  endtask

  typedef struct {
    logic mwe, mux, rwe;
    logic [15:0] res, db, rd;
    logic [7:0] cr;
    logic e_rwe;
    logic [15:0] e_data;
  } vec_t;

  typedef struct packed {
    logic [15:0] d;
    logic [7:0]  c;
  } wb_t;

  vec_t vt[7];
  vec_t v;
  wb_t  exp_q[$];
  wb_t  e;
  logic [15:0] ref_mem[16];
  logic [15:0] rsp_mem[16];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st_cnt, issued, nmem, ntxn, cycles, wait_c, tail;
    bit adv, in_txn;
    logic [15:0] t_addr;
    logic [1:0]  kind;

    //         mwe   mux   rwe   res       db        rd        cr     e_rwe e_data
    vt[0] = '{1'b0, 1'b0, 1'b1, 16'h1234, 16'h0000, 16'h0000, 8'h05, 1'b1, 16'h1234};
    vt[1] = '{1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 8'hFF, 1'b0, 16'hFFFF};
    vt[2] = '{1'b0, 1'b1, 1'b1, 16'h0040, 16'h0000, 16'hBEEF, 8'h03, 1'b1, 16'hBEEF};
    vt[3] = '{1'b1, 1'b0, 1'b1, 16'h0010, 16'hA5A5, 16'h1111, 8'h07, 1'b1, 16'h0010};
    vt[4] = '{1'b1, 1'b1, 1'b1, 16'h0022, 16'h5A5A, 16'hDEAD, 8'h09, 1'b1, 16'h0022};
    vt[5] = '{1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h0001, 8'h0A, 1'b0, 16'h0001};
    vt[6] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h7777, 8'h00, 1'b0, 16'h0000};

    // Reset held for two edges with a store request on the inputs.
    rst_n = 1'b0; idle_in(); MWE_i = 1'b1; dm_ack = 1'b0; dm_rdata = 16'h0;
    cyc(); cyc(); #1;
    chk("rst_dm_req", dm_req, 0);     chk("rst_dm_we", dm_we, 0);
    chk("rst_dm_addr", dm_addr, 0);   chk("rst_dm_wdata", dm_wdata, 0);
    chk("rst_wb_RWE", wb_RWE, 0);     chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_C_Reg", wb_C_Reg, 0); chk("rst_mem_err", mem_err, 0);
    rst_n = 1'b1; idle_in(); #1;
    chk("rst_stall", stall, 0);
    cyc();

    // Single operations with an immediate ack.
    for (int i = 0; i < 7; i++) begin
      v = vt[i];
      drv(v.mwe, v.mux, v.rwe, v.res, v.db, v.cr); dm_ack = 1'b0; #1;
      chk($sformatf("vec%0d_stall", i), stall, v.mwe | v.mux);
      if (v.mwe | v.mux) begin
        cyc(); dm_ack = 1'b1; dm_rdata = v.rd; #1;
        chk($sformatf("vec%0d_dm_req", i), dm_req, 1);
        chk($sformatf("vec%0d_dm_we", i), dm_we, v.mwe);
        chk($sformatf("vec%0d_dm_addr", i), dm_addr, v.res);
        chk($sformatf("vec%0d_dm_wdata", i), dm_wdata, v.db);
        chk($sformatf("vec%0d_ack_stall", i), stall, 0);
        chk($sformatf("vec%0d_bubble", i), wb_RWE, 0);
      end
      cyc(); dm_ack = 1'b0; idle_in(); #1;
      chk($sformatf("vec%0d_wb_RWE", i), wb_RWE, v.e_rwe);
      chk($sformatf("vec%0d_wb_data", i), wb_data, v.e_data);
      chk($sformatf("vec%0d_wb_C_Reg", i), wb_C_Reg, v.cr);
      chk($sformatf("vec%0d_req_drop", i), dm_req, 0);
    end

    // Load acknowledged on the fourth busy cycle.
    cyc();
    drv(1'b0, 1'b1, 1'b1, 16'h0040, 16'h0, 8'h11); st_cnt = 0; #1;
    if (stall) st_cnt++;
    for (int k = 0; k < 3; k++) begin
      cyc(); #1;
      chk("ld3_dm_req", dm_req, 1); chk("ld3_dm_we", dm_we, 0);
      chk("ld3_dm_addr", dm_addr, 16'h0040); chk("ld3_wb_RWE", wb_RWE, 0);
      if (stall) st_cnt++;
    end
    cyc(); dm_ack = 1'b1; dm_rdata = 16'hBEEF; #1;
    chk("ld3_pre_wb", wb_RWE, 0);
    if (stall) st_cnt++;
    cyc(); dm_ack = 1'b0; idle_in(); #1;
    chk("ld3_stall_cycles", st_cnt, 4);
    chk("ld3_wb_RWE", wb_RWE, 1); chk("ld3_wb_data", wb_data, 16'hBEEF);
    chk("ld3_wb_C_Reg", wb_C_Reg, 8'h11);
    cyc(); #1;
    chk("ld3_no_stale", wb_RWE, 0);

    // Back-to-back load then store, with spurious acks while idle.
    drv(1'b0, 1'b1, 1'b1, 16'h0005, 16'h0, 8'h21); #1;
    cyc(); dm_ack = 1'b1; dm_rdata = 16'h1357; #1;
    chk("b2b_ld_req", dm_req, 1);
    cyc(); drv(1'b1, 1'b0, 1'b0, 16'h0010, 16'hA5A5, 8'h22); dm_ack = 1'b1; dm_rdata = 16'hFFFF; #1;
    chk("b2b_gap", dm_req, 0); chk("b2b_st_stall", stall, 1);
    chk("b2b_ld_wb_RWE", wb_RWE, 1); chk("b2b_ld_wb_data", wb_data, 16'h1357);
    chk("b2b_ld_wb_C_Reg", wb_C_Reg, 8'h21);
    cyc(); dm_ack = 1'b1; dm_rdata = 16'h0; #1;
    chk("b2b_st_req", dm_req, 1); chk("b2b_st_we", dm_we, 1);
    chk("b2b_st_wdata", dm_wdata, 16'hA5A5); chk("b2b_st_addr", dm_addr, 16'h0010);
    chk("b2b_st_stall0", stall, 0); chk("b2b_st_bubble", wb_RWE, 0);
    cyc(); idle_in(); dm_ack = 1'b1; dm_rdata = 16'h9999; #1;
    chk("b2b_st_done_req", dm_req, 0); chk("b2b_st_done_we", dm_we, 0);
    chk("b2b_st_wb_RWE", wb_RWE, 0); chk("b2b_st_wb_data", wb_data, 16'h0010);
    chk("spur_stall", stall, 0);
    cyc(); dm_ack = 1'b0; #1;
    chk("spur_req", dm_req, 0); chk("spur_wb_RWE", wb_RWE, 0);

    // Reset while busy abandons the access; a late ack is ignored.
    drv(1'b0, 1'b1, 1'b1, 16'h0033, 16'h0, 8'h44); #1;
    cyc(); #1;
    chk("rstb_busy", dm_req, 1);
    rst_n = 1'b0;
    cyc(); rst_n = 1'b1; idle_in(); dm_ack = 1'b1; dm_rdata = 16'h0001; #1;
    chk("rstb_req", dm_req, 0); chk("rstb_wb_RWE", wb_RWE, 0); chk("rstb_stall", stall, 0);
    cyc(); dm_ack = 1'b0; #1;
    chk("rstb_late_ack_req", dm_req, 0); chk("rstb_late_ack_wb", wb_RWE, 0);

`ifdef MEM_TIMEOUT_EN
    // Never acked: aborted after TO busy cycles, error sticks.
    drv(1'b0, 1'b1, 1'b1, 16'h0044, 16'h0, 8'h55); #1;
    for (int k = 1; k <= TO; k++) begin
      cyc(); #1;
      chk("to_req", dm_req, 1);
      chk($sformatf("to_stall_c%0d", k), stall, (k < TO) ? 1 : 0);
      chk("to_wb_RWE", wb_RWE, 0);
    end
    cyc(); drv(1'b0, 1'b0, 1'b1, 16'h7777, 16'h0, 8'h0C); dm_ack = 1'b1; #1;
    chk("to_abort_req", dm_req, 0); chk("to_mem_err", mem_err, 1);
    chk("to_abort_wb", wb_RWE, 0); chk("to_alu_stall", stall, 0);
    cyc(); idle_in(); dm_ack = 1'b0; #1;
    chk("to_alu_wb_RWE", wb_RWE, 1); chk("to_alu_wb_data", wb_data, 16'h7777);
    chk("to_alu_wb_C_Reg", wb_C_Reg, 8'h0C); chk("to_err_sticky", mem_err, 1);
`else
    chk("no_timeout_mem_err", mem_err, 0);
`endif

    // Randomized stream against a program-order model.
    for (int i = 0; i < 16; i++) begin ref_mem[i] = 16'h0; rsp_mem[i] = 16'h0; end
    idle_in(); dm_ack = 1'b0;
    cyc(); cyc();
    issued = 0; nmem = 0; ntxn = 0; cycles = 0; wait_c = 0; tail = 0;
    adv = 1'b1; in_txn = 1'b0; t_addr = 16'h0;
    while (tail < 4 && cycles < 6000) begin
      cycles++;
      if (wb_RWE) begin
        if (exp_q.size() == 0) begin
          ncmp++; nerr++;
          $display("FAIL rnd_extra_wb: got wb_RWE=1 data %0h expected no write-back", wb_data);
        end else begin
          e = exp_q.pop_front();
          chk("rnd_wb_data", wb_data, e.d);
          chk("rnd_wb_C_Reg", wb_C_Reg, e.c);
        end
      end
      if (adv) begin
        if (issued < N_RND) begin
          kind = 2'($urandom_range(0, 3));
          MWE_i = kind[1]; Mux_i = kind[0];
          RWE_i = 1'($urandom_range(0, 1));
          Res_i = (kind == 2'd0) ? 16'($urandom) : 16'($urandom_range(0, 15));
          DATA_B_i = 16'($urandom); C_Reg_i = 8'($urandom);
          if (kind != 2'd0) nmem++;
          if (RWE_i)
            exp_q.push_back('{d: (Mux_i & ~MWE_i) ? ref_mem[Res_i[3:0]] : Res_i, c: C_Reg_i});
          if (MWE_i) ref_mem[Res_i[3:0]] = DATA_B_i;
          issued++;
        end else begin
          idle_in(); tail++;
        end
      end
      if (dm_req) begin
        if (!in_txn) begin
          in_txn = 1'b1; ntxn++; t_addr = dm_addr;
          wait_c = $urandom_range(0, 3);
        end
        chk("rnd_addr_stable", dm_addr, t_addr);
        if (wait_c == 0) begin
          dm_ack = 1'b1; dm_rdata = rsp_mem[dm_addr[3:0]];
          if (dm_we) rsp_mem[dm_addr[3:0]] = dm_wdata;
          in_txn = 1'b0;
        end else begin
          wait_c--; dm_ack = 1'b0; dm_rdata = 16'($urandom);
        end
      end else begin
        dm_ack = ($urandom_range(0, 7) == 0); dm_rdata = 16'($urandom);
      end
      #1 adv = !stall;
      cyc();
    end
    dm_ack = 1'b0;
    chk("rnd_budget", (tail >= 4), 1);
    chk("rnd_wb_drained", exp_q.size(), 0);
    chk("rnd_txn_count", ntxn, nmem);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the 16-bit pipeline. It sits directly downstream of the execute-to-memory pipeline register.
- Consumes the registered control bits (memory write enable, write-back mux select, register write enable), the ALU result, the store data and the destination register field.
- Performs load/store transactions on a req/ack data-memory port, stalling the upstream pipeline until the access completes.
- Presents registered write-back outputs to the next stage.

Parameters:
- ADDR_W, 16, data-memory address width; dm_addr = Res_i[ADDR_W-1:0] (1..16).
- TIMEOUT, 15, ack watchdog limit in cycles (used only with MEM_TIMEOUT_EN); counter width = $clog2(TIMEOUT+1).

Ports:
- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  reset, synchronous, active-low
- MWE_i  in  1  memory write enable (store)
- Mux_i  in  1  write-back select: 1 = memory read data (load), 0 = ALU result
- RWE_i  in  1  register write enable
- Res_i  in  16  ALU result / memory address
- DATA_B_i  in  16  store data
- C_Reg_i  in  8  destination register field
- stall  out  1  freeze request to the upstream pipeline register (combinational)
- dm_req  out  1  data-memory request
- dm_we  out  1  data-memory write strobe (valid while dm_req)
- dm_addr  out  ADDR_W  data-memory address
- dm_wdata  out  16  store data
- dm_rdata  in  16  load data, valid in the cycle dm_ack=1
- dm_ack  in  1  transaction complete, sampled only while dm_req=1
- wb_RWE  out  1  registered register write enable to write-back
- wb_data  out  16  registered write-back data
- wb_C_Reg  out  8  registered destination register
- mem_err  out  1  sticky timeout error (0 when feature disabled)

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset values: state=IDLE, dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0, wb_RWE=0, wb_data=0, wb_C_Reg=0, mem_err=0, latches=0.
  - Reset mid-transaction abandons it: dm_req=0 from the cycle after the reset edge. A late dm_ack is ignored.
- memop = MWE_i | Mux_i. Both bits set is treated as a store: wb_data = Res_i, no read.
- State IDLE, memop=0 (pass-through): stall=0.
  - Next edge: wb_RWE<=RWE_i, wb_data<=Res_i, wb_C_Reg<=C_Reg_i. Latency 1 cycle.
- State IDLE, memop=1: stall=1 (combinational).
  - Next edge: latch MWE_i, Mux_i, RWE_i, Res_i, DATA_B_i, C_Reg_i; go to BUSY; wb_RWE<=0 (bubble).
- State BUSY:
  - dm_req=1; dm_we=latched MWE; dm_addr, dm_wdata driven from latches (stable for the whole transaction).
  - stall = ~dm_ack.
  - On the dm_ack=1 edge: go to IDLE; wb_RWE<=latched RWE; wb_C_Reg<=latched C_Reg.
  - wb_data<=dm_rdata for a load (Mux=1, MWE=0), else latched Res.
  - Without ack: stay in BUSY, wb_RWE<=0 each cycle.
- Min memory-op latency: 2 cycles (detect + ack in the first BUSY cycle). Each extra wait cycle adds 1.
- dm_req falls in the cycle after ack (combinational from state). Back-to-back memory ops therefore always have one IDLE cycle between requests.
- dm_ack while in IDLE is ignored: no state or output change.
- A store with RWE=1 writes back latched Res (address) to the register.
- wb outputs never hold a stale write: every non-completing cycle forces wb_RWE=0.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - A counter clears on IDLE→BUSY and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT with no ack: go to IDLE, stall=0 that cycle, wb_RWE<=0, mem_err<=1 (sticky until reset).
  - A late ack after the abort is ignored.
- Undefined: no counter; BUSY waits indefinitely; mem_err tied 0.

Test Plan:
- Reset: hold rst_n=0 two cycles with MWE_i=1 → all outputs 0, stall=0 after release once inputs idle. Assert rst_n=0 during BUSY → dm_req=0 next cycle, state IDLE.
- ALU pass-through: MWE_i=0, Mux_i=0, RWE_i=1, Res_i=16'h1234, C_Reg_i=8'h05 → stall=0; next cycle wb_RWE=1, wb_data=16'h1234, wb_C_Reg=8'h05.
- Load, 3-cycle ack delay: Mux_i=1, RWE_i=1, Res_i=16'h0040, dm_rdata=16'hBEEF on ack → stall high 4 cycles; dm_addr=16'h0040, dm_we=0; wb_data=16'hBEEF, wb_RWE=1 only after the ack edge.
- Store, immediate ack: MWE_i=1, RWE_i=0, Res_i=16'h0010, DATA_B_i=16'hA5A5 → dm_we=1, dm_wdata=16'hA5A5 for exactly one dm_req cycle; wb_RWE=0 throughout.
- Back-to-back: load then store with ack in the first BUSY cycle each → one IDLE cycle between dm_req pulses; each op observed exactly once; spurious dm_ack in IDLE has no effect.
- MEM_TIMEOUT_EN, TIMEOUT=4, never ack → abort after 4 BUSY cycles; mem_err=1 and stays 1; wb_RWE=0; a subsequent ALU op still passes through.
